inst_loader: RTL and testbench

Instruction-memory loader: the write side of the instruction store that the fetch stage reads. It accepts a stream of instruction words over a valid/ready handshake and writes them to consecutive addresses of the instruction memory write port, starting at 0. When the load completes, it issues a one-cycle `cpu_start` pulse, which drives the fetch stage's `reset` input so that fetch begins from the freshly written program.

---
 rtl/inst_loader.sv | 100 ++++++++++
 tb/tb_inst_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Instruction-memory loader: streams words from a valid/ready source into
// consecutive instruction-memory addresses starting at 0. On a clean finish
// it pulses cpu_start, which is wired to the fetch stage reset.
module inst_loader #(
    parameter int A = 4,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_req,
    input  logic [W-1:0] data_in,
    input  logic         data_valid,
    input  logic         data_last,
    output logic         data_ready,
    output logic         wr_en,
    output logic [A-1:0] wr_addr,
    output logic [W-1:0] wr_data,
    output logic         cpu_start,
    output logic         loading,
    output logic [A:0]   count,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        START = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Index of the final slot; accepting here without data_last truncates.
    localparam logic [A:0] LAST_SLOT = {1'b0, {A{1'b1}}};

    state_t state;
    state_t next_state;
    logic   accept;
    logic   session_start;
    logic   full_no_last;

    // Handshake, start request and truncation decode, all from current state.
    always_comb begin
        data_ready    = (state == LOAD);
        loading       = (state == LOAD) || (state == DRAIN) || (state == START);
        accept        = (state == LOAD) && data_valid;
        session_start = ((state == IDLE) || (state == DONE)) && load_req;
        full_no_last  = accept && !data_last && (count == LAST_SLOT);
    end

    // Next-state logic; DRAIN and START each last exactly one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (load_req) next_state = LOAD;
            end
            LOAD: begin
                if (accept && data_last)  next_state = DRAIN;
                else if (full_no_last)    next_state = DONE;
            end
            DRAIN:   next_state = START;
            START:   next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // State register; reset aborts any session immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Write port, word counter, start pulse and sticky truncation flag.
    // The counter doubles as the next write address, so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cpu_start <= 1'b0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            wr_en     <= accept;
            cpu_start <= (state == DRAIN);
            if (accept) begin
                wr_addr <= count[A-1:0];
                wr_data <= data_in;
                count   <= count + 1'b1;
            end
            if (session_start) begin
                count <= '0;
                err   <= 1'b0;
            end else if (full_no_last) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed testbench for inst_loader: drives inputs at the falling edge and
// checks registered outputs at the following falling edge.
`timescale 1ns/1ps
module tb_inst_loader;

    localparam int A = 4;
    localparam int W = 9;

    logic         clk;
    logic         reset;
    logic         load_req;
    logic [W-1:0] data_in;
    logic         data_valid;
    logic         data_last;
    logic         data_ready;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         cpu_start;
    logic         loading;
    logic [A:0]   count;
    logic         err;

    int testCount;
    int failCount;
    int startPulses;
    int pulsesBefore;

    inst_loader #(.A(A), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_req   (load_req),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_last  (data_last),
        .data_ready (data_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_start  (cpu_start),
        .loading    (loading),
        .count      (count),
        .err        (err)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts cycles in which cpu_start is seen high at the falling edge.
    initial begin
        startPulses = 0;
        forever begin
            @(negedge clk);
            if (cpu_start) startPulses++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then land on the next falling edge.
    task automatic applyStimulus(input logic lr, input logic v,
                                 input logic [W-1:0] d, input logic l);
        load_req   = lr;
        data_valid = v;
        data_in    = d;
        data_last  = l;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
    endtask

    // Send one word and check the write it produces.
    task automatic sendWord(input logic [W-1:0] d, input logic l,
                            input int expAddr, input int expCount);
        applyStimulus(1'b0, 1'b1, d, l);
        checkOutput("wr_en", 32'(wr_en), 32'd1);
        checkOutput("wr_addr", 32'(wr_addr), 32'(expAddr));
        checkOutput("wr_data", 32'(wr_data), 32'(d));
        checkOutput("count", 32'(count), 32'(expCount));
    endtask

    // Walk DRAIN and START after the last word, checking the start pulse.
    task automatic checkFinish(input int expCount);
        checkOutput("drain_ready", 32'(data_ready), 32'd0);
        checkOutput("drain_start", 32'(cpu_start), 32'd0);
        checkOutput("drain_loading", 32'(loading), 32'd1);
        idleCycle();
        checkOutput("start_pulse", 32'(cpu_start), 32'd1);
        checkOutput("start_wr_en", 32'(wr_en), 32'd0);
        checkOutput("start_loading", 32'(loading), 32'd1);
        idleCycle();
        checkOutput("done_start", 32'(cpu_start), 32'd0);
        checkOutput("done_loading", 32'(loading), 32'd0);
        checkOutput("done_count", 32'(count), 32'(expCount));
        checkOutput("done_err", 32'(err), 32'd0);
    endtask

    initial begin
        testCount  = 0;
        failCount  = 0;
        reset      = 1'b1;
        load_req   = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        data_last  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        checkOutput("rst_ready", 32'(data_ready), 32'd0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_loading", 32'(loading), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        idleCycle();
        checkOutput("idle_ready", 32'(data_ready), 32'd0);

        // Basic load of three words
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("load_ready", 32'(data_ready), 32'd1);
        checkOutput("load_loading", 32'(loading), 32'd1);
        sendWord(9'h001, 1'b0, 0, 1);
        sendWord(9'h0A5, 1'b0, 1, 2);
        sendWord(9'h1FF, 1'b1, 2, 3);
        pulsesBefore = startPulses;
        checkFinish(3);
        checkOutput("basic_pulses", 32'(startPulses - pulsesBefore), 32'd1);
        checkOutput("basic_hold_addr", 32'(wr_addr), 32'd2);

        // Gapped stream of four words, reloaded from DONE
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("gap_count0", 32'(count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            sendWord(9'(9'h010 + i), (i == 3), i, i + 1);
            if (i != 3) begin
                idleCycle();
                checkOutput("gap_wr_en", 32'(wr_en), 32'd0);
                checkOutput("gap_hold_addr", 32'(wr_addr), 32'(i));
                checkOutput("gap_hold_data", 32'(wr_data), 32'(9'h010 + i));
            end
        end
        checkFinish(4);

        // Overflow: sixteen words with no last marker
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        pulsesBefore = startPulses;
        for (int i = 0; i < 16; i++) sendWord(9'(9'h100 + i), 1'b0, i, i + 1);
        checkOutput("ovf_ready", 32'(data_ready), 32'd0);
        checkOutput("ovf_err", 32'(err), 32'd1);
        checkOutput("ovf_loading", 32'(loading), 32'd0);
        applyStimulus(1'b0, 1'b1, 9'h1AA, 1'b0);
        checkOutput("ovf_17_wr_en", 32'(wr_en), 32'd0);
        checkOutput("ovf_17_addr", 32'(wr_addr), 32'd15);
        checkOutput("ovf_17_count", 32'(count), 32'd16);
        idleCycle();
        idleCycle();
        checkOutput("ovf_no_start", 32'(startPulses - pulsesBefore), 32'd0);
        checkOutput("ovf_err_sticky", 32'(err), 32'd1);

        // Exact fill: reload from DONE clears err, last on word sixteen
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("fill_err_clr", 32'(err), 32'd0);
        checkOutput("fill_count0", 32'(count), 32'd0);
        pulsesBefore = startPulses;
        for (int i = 0; i < 16; i++) sendWord(9'(9'h0C0 + i), (i == 15), i, i + 1);
        checkFinish(16);
        checkOutput("fill_pulses", 32'(startPulses - pulsesBefore), 32'd1);
        checkOutput("fill_last_addr", 32'(wr_addr), 32'd15);

        // load_req pulsed during LOAD is ignored
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        sendWord(9'h021, 1'b0, 0, 1);
        sendWord(9'h022, 1'b0, 1, 2);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("req_in_load_count", 32'(count), 32'd2);
        checkOutput("req_in_load_ready", 32'(data_ready), 32'd1);
        sendWord(9'h023, 1'b0, 2, 3);

        // Asynchronous reset mid-load after five accepted words
        sendWord(9'h024, 1'b0, 3, 4);
        sendWord(9'h025, 1'b0, 4, 5);
        pulsesBefore = startPulses;
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("arst_addr", 32'(wr_addr), 32'd0);
        checkOutput("arst_data", 32'(wr_data), 32'd0);
        checkOutput("arst_count", 32'(count), 32'd0);
        checkOutput("arst_ready", 32'(data_ready), 32'd0);
        checkOutput("arst_loading", 32'(loading), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idleCycle();
        checkOutput("arst_no_start", 32'(startPulses - pulsesBefore), 32'd0);

        // In IDLE, load_req together with data_valid does not accept the word
        applyStimulus(1'b1, 1'b1, 9'h155, 1'b0);
        checkOutput("idle_req_wr_en", 32'(wr_en), 32'd0);
        checkOutput("idle_req_count", 32'(count), 32'd0);
        checkOutput("idle_req_ready", 32'(data_ready), 32'd1);
        sendWord(9'h0AA, 1'b0, 0, 1);
        sendWord(9'h0BB, 1'b1, 1, 2);
        checkFinish(2);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
